instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Front-end fetch stage directly upstream of the MMU's instruction port. Owns the fetch PC and drives instructionMemoryAddress. Accepts words when the MMU reports instructionMemorySuccess and queues them with their PC in a small buffer for decode. Handles branch redirects, including a redirect that arrives while a cache miss is outstanding, without changing the address mid-miss.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
instructionMemoryAddress  output  32  fetch address to MMU; driven directly from a register, never combinational from inputs.
instructionMemoryDataOut  input  32  instruction word from MMU.
instructionMemorySuccess  input  1  MMU word valid for the current address; may be high in the same cycle the address is presented (hit or peripheral).
branchTaken  input  1  redirect request from execute, single-cycle pulse.
branchTarget  input  32  redirect target, sampled when branchTaken=1.
decodeReady  input  1  decode consumes the head entry this cycle if instructionValid=1.
instruction  output  32  head-of-buffer instruction word.
instructionPC  output  32  PC of the head entry.
instructionValid  output  1  buffer non-empty.
fetchMisaligned  output  1  one-cycle pulse: branchTarget[1:0]!=0 was accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): fetchPC=RESET_PC, state=RUN, count=0, read/write pointers=0, fetchMisaligned=0. Outputs: instructionMemoryAddress=RESET_PC, instructionValid=0. Buffer data is don't-care.
- instructionMemoryAddress = fetchPC in RUN; = heldPC in HOLD (see below).
- accept = instructionMemorySuccess & state==RUN & ~branchTaken & (count<DEPTH | pop).
- pop = instructionValid & decodeReady.
- On accept: write {fetchPC, instructionMemoryDataOut} at the write pointer; fetchPC <= fetchPC+4 (wraps mod 2^32); write pointer advances.
- Buffer full and no pop: the success is ignored and fetchPC is held. The address stays stable; the word is re-fetched later.
- Simultaneous push and pop: count unchanged. Push is allowed when full only if a pop occurs in the same cycle.
- Pointers wrap mod DEPTH. count ranges 0..DEPTH.
- Redirect in RUN with instructionMemorySuccess=1: flush (count=0, pointers=0). The returned word is discarded. fetchPC <= {branchTarget[31:2],2'b00}. State stays RUN. The new address appears the next cycle.
- Redirect in RUN with instructionMemorySuccess=0 (miss outstanding): flush the buffer. Latch pendingTarget={branchTarget[31:2],2'b00}. Go to HOLD. The address stays at the old fetchPC.
- HOLD state: the address is held and no pushes occur. A new branchTaken overwrites pendingTarget. When instructionMemorySuccess=1, the word is discarded, fetchPC <= pendingTarget (or the same-cycle branchTarget if branchTaken), and the state returns to RUN.
- Flush priority: flush beats pop and push in the same cycle. A pop in the flush cycle is still seen by decode, since decode itself squashes on branchTaken.
- fetchMisaligned is asserted the cycle after any accepted branchTaken whose target[1:0]!=0. The target is always force-aligned.
- No combinational path from decodeReady or branchTaken to instructionMemoryAddress.
- Reset asserted mid-miss or in HOLD returns the block to the reset state immediately. Any later success for the old address is treated as a normal response to RESET_PC only if it arrives after reset is released. MMU/cache must be reset together.

Test Plan:
- Reset, then instructionMemorySuccess=1 every cycle with decodeReady=1 -> instructionPC sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles; instructionValid=1 from the cycle after the first success.
- decodeReady=0, success=1 continuously -> count saturates at 2; address holds at 0x8; instructionPC stays 0x0. Raising decodeReady resumes at 0x8 with no gap or duplicate.
- branchTaken with target 0x100 while success=1 -> instructionValid=0 next cycle; address 0x100 next cycle; the word at the old address is never delivered.
- At address 0x40, success=0 for 3 cycles; branchTaken target 0x200 in cycle 1 -> address stays 0x40 until success; that word is dropped; next address 0x200; first delivered PC is 0x200.
- In HOLD, second branchTaken target 0x300 before success -> after success, address 0x300, not the first target.
- branchTaken target 0x103 -> fetchMisaligned pulses one cycle; fetch resumes at 0x100. Separately, fetchPC 0xFFFF_FFFC plus success -> next address 0x0000_0000.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, presents it to the MMU,
// and queues returned words with their PC in a small buffer for decode.
// A redirect during an outstanding miss holds the address until that
// miss resolves, then jumps to the latest pending target.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instructionMemoryAddress,
    input  logic [31:0] instructionMemoryDataOut,
    input  logic        instructionMemorySuccess,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        decodeReady,
    output logic [31:0] instruction,
    output logic [31:0] instructionPC,
    output logic        instructionValid,
    output logic        fetchMisaligned
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [31:0]     pending_reg, pending_next;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic            misaligned_reg;

    logic [31:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_data [DEPTH];

    logic [31:0]     target_aligned;
    logic            pop;
    logic            push;
    logic            flush;

    assign target_aligned = {branchTarget[31:2], 2'b00};
    assign pop            = instructionValid & decodeReady;
    assign push           = instructionMemorySuccess & (state_reg == RUN) & ~branchTaken
                            & ((count_reg < DEPTH_C) | pop);
    // Every redirect empties the buffer; in HOLD it is already empty.
    assign flush          = branchTaken;

    // The address is always the registered fetch PC: during HOLD the PC
    // simply is not advanced, so it stays at the missed address.
    assign instructionMemoryAddress = fetch_pc_reg;
    assign instructionValid         = (count_reg != '0);
    assign instruction              = mem_data[rd_ptr_reg];
    assign instructionPC            = mem_pc[rd_ptr_reg];
    assign fetchMisaligned          = misaligned_reg;

    // State, PC and pending-target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            fetch_pc_reg <= RESET_PC;
            pending_reg  <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            pending_reg  <= pending_next;
        end
    end

    // Next-state: redirect handling and sequential PC advance.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        pending_next  = pending_reg;
        case (state_reg)
            RUN: begin
                if (branchTaken) begin
                    if (instructionMemorySuccess) begin
                        fetch_pc_next = target_aligned;
                    end else begin
                        pending_next = target_aligned;
                        state_next   = HOLD;
                    end
                end else if (push) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            HOLD: begin
                if (instructionMemorySuccess) begin
                    // The word for the stale address is dropped here.
                    fetch_pc_next = branchTaken ? target_aligned : pending_reg;
                    state_next    = RUN;
                end else if (branchTaken) begin
                    pending_next = target_aligned;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Buffer occupancy and pointers; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push && !pop)
                count_reg <= count_reg + (PW + 1)'(1);
            else if (pop && !push)
                count_reg <= count_reg - (PW + 1)'(1);
        end
    end

    // Buffer storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_reg]   <= fetch_pc_reg;
            mem_data[wr_ptr_reg] <= instructionMemoryDataOut;
        end
    end

    // One-cycle flag for a redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misaligned_reg <= 1'b0;
        else
            misaligned_reg <= branchTaken & (branchTarget[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table applied one
// cycle per row, plus hand-written reset corner sequences.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instructionMemoryAddress;
    logic [31:0] instructionMemoryDataOut;
    logic        instructionMemorySuccess;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        decodeReady;
    logic [31:0] instruction;
    logic [31:0] instructionPC;
    logic        instructionValid;
    logic        fetchMisaligned;

    int n_cmp;
    int n_bad;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .instructionMemoryAddress (instructionMemoryAddress),
        .instructionMemoryDataOut (instructionMemoryDataOut),
        .instructionMemorySuccess (instructionMemorySuccess),
        .branchTaken              (branchTaken),
        .branchTarget             (branchTarget),
        .decodeReady              (decodeReady),
        .instruction              (instruction),
        .instructionPC            (instructionPC),
        .instructionValid         (instructionValid),
        .fetchMisaligned          (fetchMisaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: each word is a fixed function of its address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign instructionMemoryDataOut = word_of(instructionMemoryAddress);

    typedef struct {
        logic        succ;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic succ, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.succ = succ; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic succ, input logic br, input logic [31:0] tgt,
                         input logic rdy);
        instructionMemorySuccess = succ;
        branchTaken              = br;
        branchTarget             = tgt;
        decodeReady              = rdy;
    endtask

    task automatic check_outputs(input int row, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_pc,
                                 input logic e_mis);
        chk("addr", row, instructionMemoryAddress, e_addr);
        chk("valid", row, {31'd0, instructionValid}, {31'd0, e_valid});
        chk("misaligned", row, {31'd0, fetchMisaligned}, {31'd0, e_mis});
        if (e_valid) begin
            chk("pc", row, instructionPC, e_pc);
            chk("instr", row, instruction, word_of(e_pc));
        end
        $display("row %0d: addr=%h valid=%0b pc=%h instr=%h mis=%0b", row,
                 instructionMemoryAddress, instructionValid, instructionPC,
                 instruction, fetchMisaligned);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        //   succ br  tgt            rdy  addr           valid pc             mis
        // Streaming from reset with decode always ready.
        add(1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 0);
        add(1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004, 0);
        add(1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0008, 0);
        add(1, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_000C, 0);
        // Decode stalls: buffer fills to two, then success is ignored.
        add(1, 0, 32'h0,         0, 32'h0000_0014, 1, 32'h0000_000C, 0);
        add(1, 0, 32'h0,         0, 32'h0000_0014, 1, 32'h0000_000C, 0);
        add(1, 0, 32'h0,         0, 32'h0000_0014, 1, 32'h0000_000C, 0);
        // Full with pop: push allowed, no gap and no duplicate.
        add(1, 0, 32'h0,         1, 32'h0000_0018, 1, 32'h0000_0010, 0);
        add(1, 0, 32'h0,         1, 32'h0000_001C, 1, 32'h0000_0014, 0);
        // Redirect on a hit: flush, new address next cycle.
        add(1, 1, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0,         0);
        add(1, 0, 32'h0,         1, 32'h0000_0104, 1, 32'h0000_0100, 0);
        // Misaligned target: forced alignment plus one-cycle flag.
        add(1, 1, 32'h0000_0103, 1, 32'h0000_0100, 0, 32'h0,         1);
        add(1, 0, 32'h0,         1, 32'h0000_0104, 1, 32'h0000_0100, 0);
        // Redirect during a miss at 0x40: address held until success.
        add(1, 1, 32'h0000_0040, 1, 32'h0000_0040, 0, 32'h0,         0);
        add(0, 1, 32'h0000_0200, 1, 32'h0000_0040, 0, 32'h0,         0);
        add(0, 0, 32'h0,         1, 32'h0000_0040, 0, 32'h0,         0);
        add(0, 0, 32'h0,         1, 32'h0000_0040, 0, 32'h0,         0);
        add(1, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0,         0);
        add(1, 0, 32'h0,         1, 32'h0000_0204, 1, 32'h0000_0200, 0);
        // Second redirect while held replaces the pending target.
        add(0, 1, 32'h0000_02F0, 1, 32'h0000_0204, 0, 32'h0,         0);
        add(0, 1, 32'h0000_0300, 1, 32'h0000_0204, 0, 32'h0,         0);
        add(1, 0, 32'h0,         1, 32'h0000_0300, 0, 32'h0,         0);
        add(1, 0, 32'h0,         1, 32'h0000_0304, 1, 32'h0000_0300, 0);
        // Redirect arriving with the resolving success wins over pending.
        add(0, 1, 32'h0000_0500, 1, 32'h0000_0304, 0, 32'h0,         0);
        add(1, 1, 32'h0000_0601, 1, 32'h0000_0600, 0, 32'h0,         1);
        add(1, 0, 32'h0,         1, 32'h0000_0604, 1, 32'h0000_0600, 0);
        // PC wraps from the top of the address space.
        add(1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        add(1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
        add(0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].succ, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_mis);
        end

        // Enter HOLD at address 0x0 with a pending target, then reset
        // asynchronously between clock edges.
        drive(1'b0, 1'b1, 32'h0000_0700, 1'b1);
        @(posedge clk);
        #1;
        check_outputs(100, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_outputs(101, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // After release, success is a normal response to RESET_PC.
        @(posedge clk);
        #1;
        check_outputs(102, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0);
        @(posedge clk);
        #1;
        check_outputs(103, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0);

        // Reset with a non-empty buffer clears occupancy immediately.
        rst_n = 1'b0;
        #1;
        check_outputs(104, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
